weight_writeback: RTL

- Write side of the weight memory: the training path no longer treats weights as ROM.
- After back-propagation produces one gradient per weight, this block reads each stored weight, applies w_new = w_old - (grad >>> LR_SHIFT), saturates the result and writes it back.
- It walks all N_WEIGHTS addresses once per start.
- It sits between the back-propagation datapath (upstream, valid/ready stream) and a single-port weight BRAM (downstream).

---
 rtl/nn_pkg.sv | 23 ++
 rtl/weight_sat_update.sv | 34 +++
 rtl/weight_writeback.sv | 120 ++++++++++++
 3 files changed

// File: rtl/nn_pkg.sv
// Shared constants and types for the weight update path.
package nn_pkg;

   localparam int N_WEIGHTS = 784;
   localparam int ADDR_W    = 10;
   localparam int WORD_W    = 12;
   localparam int GRAD_W    = 32;
   localparam int LR_SHIFT  = 8;

   // Saturation bounds of the stored two's-complement weight.
   localparam logic signed [WORD_W-1:0] WMAX = {1'b0, {(WORD_W-1){1'b1}}};
   localparam logic signed [WORD_W-1:0] WMIN = {1'b1, {(WORD_W-1){1'b0}}};

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_RD,
      ST_WAIT,
      ST_CALC,
      ST_WR,
      ST_DONE
   } wb_state_e;

endpackage

// File: rtl/weight_sat_update.sv
// Combinational weight update: w_new = sat(w_old - (grad >>> LR_SHIFT)).
module weight_sat_update
   import nn_pkg::*;
(
   input  logic signed [WORD_W-1:0] w_old,
   input  logic signed [GRAD_W-1:0] grad,
   output logic signed [WORD_W-1:0] w_new,
   output logic                     clipped
);

   // One guard bit above the gradient width keeps the subtraction exact.
   localparam logic signed [GRAD_W:0] DIFF_MAX = {{(GRAD_W+1-WORD_W){WMAX[WORD_W-1]}}, WMAX};
   localparam logic signed [GRAD_W:0] DIFF_MIN = {{(GRAD_W+1-WORD_W){WMIN[WORD_W-1]}}, WMIN};

   logic signed [GRAD_W-1:0] delta;
   logic signed [GRAD_W:0]   diff;

   // Scale the gradient, subtract, and clamp into the stored word range.
   always_comb begin
      delta   = grad >>> LR_SHIFT;
      diff    = $signed({{(GRAD_W+1-WORD_W){w_old[WORD_W-1]}}, w_old})
              - $signed({delta[GRAD_W-1], delta});
      w_new   = diff[WORD_W-1:0];
      clipped = 1'b0;
      if (diff > DIFF_MAX) begin
         w_new   = WMAX;
         clipped = 1'b1;
      end else if (diff < DIFF_MIN) begin
         w_new   = WMIN;
         clipped = 1'b1;
      end
   end

endmodule

// File: rtl/weight_writeback.sv
// Read-modify-write sweep over the weight BRAM, one gradient per address.
//
// state | meaning
// IDLE  | waiting for start
// RD    | issue BRAM read of addr
// WAIT  | read latency; capture mem_rdata into w_old
// CALC  | offer grad_ready; on handshake register updated weight
// WR    | write updated weight back to addr
// DONE  | one-cycle done pulse, then IDLE
module weight_writeback
   import nn_pkg::*;
#(
   parameter int N_WEIGHTS = nn_pkg::N_WEIGHTS
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     start,
   output logic                     busy,
   output logic                     done,
   input  logic                     grad_valid,
   output logic                     grad_ready,
   input  logic signed [GRAD_W-1:0] grad_data,
   output logic                     mem_en,
   output logic                     mem_we,
   output logic [ADDR_W-1:0]        mem_addr,
   output logic [WORD_W-1:0]        mem_wdata,
   input  logic [WORD_W-1:0]        mem_rdata,
   output logic [ADDR_W-1:0]        sat_count
);

   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(N_WEIGHTS - 1);

   wb_state_e                state_q, state_d;
   logic [ADDR_W-1:0]        addr_q;
   logic [ADDR_W-1:0]        sat_q;
   logic signed [WORD_W-1:0] w_old_q;
   logic signed [WORD_W-1:0] wdata_q;
   logic signed [WORD_W-1:0] w_new;
   logic                     clipped;

   weight_sat_update u_sat (
      .w_old   (w_old_q),
      .grad    (grad_data),
      .w_new   (w_new),
      .clipped (clipped)
   );

   assign mem_addr  = addr_q;
   assign mem_wdata = wdata_q;
   assign sat_count = sat_q;

   // State register; reset aborts any pass in flight.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= ST_IDLE;
      else     state_q <= state_d;
   end

   // Address, captured read data, write data and clip counter.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         addr_q  <= '0;
         sat_q   <= '0;
         w_old_q <= '0;
         wdata_q <= '0;
      end else begin
         case (state_q)
            ST_IDLE: if (start) begin
               addr_q <= '0;
               sat_q  <= '0;
            end
            ST_WAIT: w_old_q <= mem_rdata;
            ST_CALC: if (grad_valid) begin
               wdata_q <= w_new;
               if (clipped && (sat_q != '1)) sat_q <= sat_q + 1'b1;
            end
            ST_WR:   if (addr_q != LAST_ADDR) addr_q <= addr_q + 1'b1;
            default: ;
         endcase
      end
   end

   // Next state and state-decoded outputs; decoding from state lets reset drop mem_en/mem_we at once.
   always_comb begin
      state_d    = state_q;
      busy       = 1'b0;
      done       = 1'b0;
      grad_ready = 1'b0;
      mem_en     = 1'b0;
      mem_we     = 1'b0;
      case (state_q)
         ST_IDLE: if (start) state_d = ST_RD;
         ST_RD: begin
            busy    = 1'b1;
            mem_en  = 1'b1;
            state_d = ST_WAIT;
         end
         ST_WAIT: begin
            busy    = 1'b1;
            state_d = ST_CALC;
         end
         ST_CALC: begin
            busy       = 1'b1;
            grad_ready = 1'b1;
            if (grad_valid) state_d = ST_WR;
         end
         ST_WR: begin
            busy    = 1'b1;
            mem_en  = 1'b1;
            mem_we  = 1'b1;
            state_d = (addr_q == LAST_ADDR) ? ST_DONE : ST_RD;
         end
         ST_DONE: begin
            done    = 1'b1;
            state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

endmodule
